// File: rtl/register_file_pkg.sv
// Shared constants and word/index types for the datapath register file.
package register_file_pkg;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_INDEX_W = 2;

  typedef logic [DEF_WIDTH-1:0]   reg_word_t;
  typedef logic [DEF_INDEX_W-1:0] reg_index_t;
endpackage

// File: rtl/register_file_if.sv
// Write port plus two read ports between the controller/ALU and the register file.
// There is no valid/ready pair: write_enable alone qualifies a write, and the
// register file never stalls, so every request is taken on the next rising edge.
interface register_file_if #(
  parameter int WIDTH   = register_file_pkg::DEF_WIDTH,
  parameter int INDEX_W = register_file_pkg::DEF_INDEX_W
);
  logic               write_enable;
  logic [INDEX_W-1:0] write_index;
  logic [WIDTH-1:0]   write_data;
  logic [INDEX_W-1:0] read_index_a;
  logic [WIDTH-1:0]   read_data_a;
  logic [INDEX_W-1:0] read_index_b;
  logic [WIDTH-1:0]   read_data_b;

  modport master (
    output write_enable, write_index, write_data,
    output read_index_a, read_index_b,
    input  read_data_a, read_data_b
  );

  modport slave (
    input  write_enable, write_index, write_data,
    input  read_index_a, read_index_b,
    output read_data_a, read_data_b
  );
endinterface

// File: rtl/register_file_entry.sv
// One register word with asynchronous active-low clear and a load enable.
module register_file_entry #(
  parameter int WIDTH = register_file_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register file: one synchronous write port, two combinational read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic            clk,
  input  logic            reset,
  register_file_if.slave  bus
);
  logic [DEPTH-1:0] w_load;
  logic [WIDTH-1:0] w_q [DEPTH];
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  // Indices at or above DEPTH match no entry: such writes drop and such reads give 0.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_load[i] = bus.write_enable && (bus.write_index == INDEX_W'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    register_file_entry #(.WIDTH(WIDTH)) u_entry (
      .clk     (clk),
      .i_rst_n (reset),
      .i_load  (w_load[g]),
      .i_d     (bus.write_data),
      .o_q     (w_q[g])
    );
  end

  // No write-to-read bypass: reads see the stored value until the edge commits.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.read_index_a == INDEX_W'(i)) w_rd_a = w_q[i];
      if (bus.read_index_b == INDEX_W'(i)) w_rd_b = w_q[i];
    end
  end

  assign bus.read_data_a = w_rd_a;
  assign bus.read_data_b = w_rd_b;
endmodule

// File: tb/tb_register_file.sv
// Directed and random checks of register_file against an array model of the registers.
module tb_register_file;
  import register_file_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   cmp_en;

  reg_word_t model [DEF_DEPTH];

  register_file_if #(.WIDTH(DEF_WIDTH), .INDEX_W(DEF_INDEX_W)) bus ();

  register_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: reset wipes everything at once; otherwise an enabled edge stores the word.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEF_DEPTH; i++) model[i] = '0;
    end else if (bus.write_enable) begin
      model[bus.write_index] = bus.write_data;
    end
  end

  task automatic chk(input string name, input reg_word_t got, input reg_word_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h want 0x%04h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: both read ports against the model, mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_a", bus.read_data_a, model[bus.read_index_a]);
      chk("model_b", bus.read_data_b, model[bus.read_index_b]);
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic we, input reg_index_t idx, input reg_word_t data);
    bus.write_enable = we;
    bus.write_index  = idx;
    bus.write_data   = data;
  endtask

  task automatic set_rd(input reg_index_t ia, input reg_index_t ib);
    bus.read_index_a = ia;
    bus.read_index_b = ib;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    cmp_en = 1'b0;
    reset  = 1'b0;
    set_wr(1'b0, 2'd0, 16'h0000);
    set_rd(2'd0, 2'd0);
    step();
    step();
    cmp_en = 1'b1;

    // Reset state: every register reads zero on both ports.
    for (int i = 0; i < DEF_DEPTH; i++) begin
      set_rd(reg_index_t'(i), reg_index_t'(DEF_DEPTH - 1 - i));
      #1;
      chk("reset_a", bus.read_data_a, 16'h0000);
      chk("reset_b", bus.read_data_b, 16'h0000);
    end
    reset = 1'b1;
    step();

    // Async clear between edges.
    set_wr(1'b1, 2'd2, 16'hABCD);
    step();
    set_wr(1'b0, 2'd0, 16'h0000);
    set_rd(2'd2, 2'd2);
    #1;
    chk("wr_r2", bus.read_data_a, 16'hABCD);
    #1;
    reset = 1'b0;
    #1;
    chk("async_clear", bus.read_data_a, 16'h0000);
    reset = 1'b1;
    step();

    // Basic write/read.
    set_wr(1'b1, 2'd1, 16'h1234);
    step();
    set_wr(1'b0, 2'd0, 16'h0000);
    set_rd(2'd1, 2'd0);
    #1;
    chk("basic_a", bus.read_data_a, 16'h1234);
    chk("basic_b", bus.read_data_b, 16'h0000);

    // Write disabled leaves r1 alone.
    set_wr(1'b0, 2'd1, 16'hFFFF);
    step();
    #1;
    chk("we0_hold", bus.read_data_a, 16'h1234);

    // Read-during-write on r3: old value before the edge, new value after.
    set_wr(1'b1, 2'd3, 16'h5A5A);
    set_rd(2'd3, 2'd3);
    #1;
    chk("rdw_old", bus.read_data_a, 16'h0000);
    step();
    set_wr(1'b0, 2'd0, 16'h0000);
    #1;
    chk("rdw_new_a", bus.read_data_a, 16'h5A5A);
    chk("rdw_new_b", bus.read_data_b, 16'h5A5A);

    // Reset priority over a pending write.
    reset = 1'b0;
    set_wr(1'b1, 2'd0, 16'h7777);
    step();
    step();
    reset = 1'b1;
    set_wr(1'b0, 2'd0, 16'h0000);
    set_rd(2'd0, 2'd1);
    #1;
    chk("rst_prio_r0", bus.read_data_a, 16'h0000);
    chk("rst_prio_r1", bus.read_data_b, 16'h0000);

    // First edge after release honours a write; fill all entries.
    for (int i = 0; i < DEF_DEPTH; i++) begin
      set_wr(1'b1, reg_index_t'(i), reg_word_t'(16'h1111 * (i + 1)));
      step();
    end
    set_wr(1'b0, 2'd0, 16'h0000);
    set_rd(2'd0, 2'd3);
    #1;
    chk("fill_r0", bus.read_data_a, 16'h1111);
    chk("fill_r3", bus.read_data_b, 16'h4444);
    set_rd(2'd2, 2'd1);
    #1;
    chk("fill_r2", bus.read_data_a, 16'h3333);
    chk("fill_r1", bus.read_data_b, 16'h2222);

    // Random regression with occasional reset.
    for (int n = 0; n < 300; n++) begin
      reset = ($urandom_range(99) == 0) ? 1'b0 : 1'b1;
      set_wr(1'($urandom_range(1)), reg_index_t'($urandom_range(DEF_DEPTH - 1)),
             reg_word_t'($urandom_range(16'hFFFF)));
      set_rd(reg_index_t'($urandom_range(DEF_DEPTH - 1)),
             reg_index_t'($urandom_range(DEF_DEPTH - 1)));
      step();
    end
    reset = 1'b1;
    step();
    step();
    cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
